// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the Mini-SRC ALU datapath.
// Fetches over the shared bus, decodes IR[31:27], and issues one-hot
// register-transfer strobes each cycle for R-format, mul/div, neg/not,
// nop and halt.
//
// Ports:
//   clock      system clock (rising edge)
//   clear      asynchronous active-low reset (forces IDLE)
//   run_in     start request, sampled in IDLE only
//   mem_ready  memory read complete, sampled in T1 only
//   IR         current instruction register contents
//   PCout..LOin  datapath strobes (Moore, decoded from state + IR fields)
//   reg_sel    register-file select for Rout/Rin, 0 otherwise
//   alu_op     ALU opcode during the execute Zin state, 0 otherwise
//   run        high outside IDLE and HALTED
//   halted     high only in HALTED
module alu_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned REGW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run_in,
  input  logic            mem_ready,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Rout,
  output logic            Rin,
  output logic            HIin,
  output logic            LOin,
  output logic [REGW-1:0] reg_sel,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            halted
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_R3     = 4'd4,
    S_R4     = 4'd5,
    S_R5     = 4'd6,
    S_M3     = 4'd7,
    S_M4     = 4'd8,
    S_M5     = 4'd9,
    S_M6     = 4'd10,
    S_U3     = 4'd11,
    S_U4     = 4'd12,
    S_HALTED = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [4:0] w_opcode;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_unused;

  assign w_opcode = IR[31:27];
  assign w_ra     = IR[26:23];
  assign w_rb     = IR[22:19];
  assign w_rc     = IR[18:15];
  assign w_unused = ^IR[14:0];

  // State register; clear drops straight to IDLE, mid-instruction included.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next_state = r_state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Rout     = 1'b0;
    Rin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    reg_sel  = '0;
    alu_op   = '0;
    run      = 1'b1;
    halted   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        run = 1'b0;
        if (run_in) w_next_state = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next_state = S_T1;
      end
      // Z still holds PC+1 while waiting, so re-asserting PCin is harmless.
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) w_next_state = S_T2;
      end
      // Decode from the IR input value being latched this cycle.
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        case (w_opcode)
          OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
          OP_ROR, OP_ROL, OP_AND, OP_OR:  w_next_state = S_R3;
          OP_MUL, OP_DIV:                 w_next_state = S_M3;
          OP_NEG, OP_NOT:                 w_next_state = S_U3;
          OP_HALT:                        w_next_state = S_HALTED;
          default:                        w_next_state = S_T0;
        endcase
      end
      S_R3: begin
        Rout = 1'b1; Yin = 1'b1; reg_sel = REGW'(w_rb);
        w_next_state = S_R4;
      end
      S_R4: begin
        Rout = 1'b1; Zin = 1'b1; reg_sel = REGW'(w_rc); alu_op = OPW'(w_opcode);
        w_next_state = S_R5;
      end
      S_R5: begin
        Zlowout = 1'b1; Rin = 1'b1; reg_sel = REGW'(w_ra);
        w_next_state = S_T0;
      end
      S_M3: begin
        Rout = 1'b1; Yin = 1'b1; reg_sel = REGW'(w_ra);
        w_next_state = S_M4;
      end
      S_M4: begin
        Rout = 1'b1; Zin = 1'b1; reg_sel = REGW'(w_rb); alu_op = OPW'(w_opcode);
        w_next_state = S_M5;
      end
      S_M5: begin
        Zlowout = 1'b1; LOin = 1'b1;
        w_next_state = S_M6;
      end
      S_M6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        w_next_state = S_T0;
      end
      S_U3: begin
        Rout = 1'b1; Zin = 1'b1; reg_sel = REGW'(w_rb); alu_op = OPW'(w_opcode);
        w_next_state = S_U4;
      end
      S_U4: begin
        Zlowout = 1'b1; Rin = 1'b1; reg_sel = REGW'(w_ra);
        w_next_state = S_T0;
      end
      S_HALTED: begin
        run    = 1'b0;
        halted = 1'b1;
      end
      default: begin
        run = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: steps the machine through reset,
// R-format, memory wait, mul, not, undefined opcode and halt, checking the
// full output vector against hand-computed per-state values.
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        run_in;
  logic        mem_ready;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, Rout, Rin, HIin, LOin;
  logic [3:0]  reg_sel;
  logic [4:0]  alu_op;
  logic        run;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Strobe order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read
  //               MDRin MDRout IRin Yin Rout Rin HIin LOin
  localparam logic [15:0] E_NONE = 16'h0000;
  localparam logic [15:0] E_T0   = 16'hF000;
  localparam logic [15:0] E_T1   = 16'h0B80;
  localparam logic [15:0] E_T2   = 16'h0060;
  localparam logic [15:0] E_RY   = 16'h0018;  // Rout + Yin
  localparam logic [15:0] E_RZ   = 16'h1008;  // Rout + Zin
  localparam logic [15:0] E_WB   = 16'h0804;  // Zlowout + Rin
  localparam logic [15:0] E_M5   = 16'h0801;  // Zlowout + LOin
  localparam logic [15:0] E_M6   = 16'h0402;  // Zhighout + HIin

  localparam logic [31:0] IR_ADD_A = 32'h1891_0000;  // add R1,R2,R2
  localparam logic [31:0] IR_ADD   = 32'h1891_8000;  // add R1,R2,R3
  localparam logic [31:0] IR_MUL   = 32'h7A28_0000;  // mul R4,R5
  localparam logic [31:0] IR_NOT   = 32'h9338_0000;  // not R6,R7
  localparam logic [31:0] IR_UNDEF = 32'hF800_0000;  // opcode 11111
  localparam logic [31:0] IR_HALT  = 32'hD800_0000;  // halt

  alu_sequencer dut (
    .clock(clock), .clear(clear), .run_in(run_in), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Rout(Rout), .Rin(Rin), .HIin(HIin), .LOin(LOin),
    .reg_sel(reg_sel), .alu_op(alu_op), .run(run), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] e_str, input logic [3:0] e_sel,
                     input logic [4:0] e_op, input logic e_run, input logic e_halt);
    logic [26:0] obs;
    logic [26:0] exp;
    obs = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
           MDRin, MDRout, IRin, Yin, Rout, Rin, HIin, LOin,
           reg_sel, alu_op, run, halted};
    exp = {e_str, e_sel, e_op, e_run, e_halt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b0; run_in = 1'b0; mem_ready = 1'b0; IR = IR_ADD_A;
    tick(); tick();
    chk("reset", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    chk("idle_hold", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);

    // Reset mid-instruction at R4 of add
    run_in = 1'b1; mem_ready = 1'b1;
    tick(); chk("rst_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("rst_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("rst_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("rst_r3", E_RY, 4'd2, 5'd0, 1'b1, 1'b0);
    tick(); chk("rst_r4", E_RZ, 4'd2, 5'd3, 1'b1, 1'b0);
    #2 clear = 1'b0; run_in = 1'b0;
    #1 chk("async_clear", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);
    tick(); chk("clear_edge", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);

    // add R1,R2,R3 with no memory wait; run_in stays high from here
    IR = IR_ADD; clear = 1'b1; run_in = 1'b1;
    tick(); chk("add_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("add_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("add_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("add_r3", E_RY, 4'd2, 5'd0, 1'b1, 1'b0);
    tick(); chk("add_r4", E_RZ, 4'd3, 5'b00011, 1'b1, 1'b0);
    tick(); chk("add_r5", E_WB, 4'd1, 5'd0, 1'b1, 1'b0);
    tick(); chk("add_next_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);

    // not R6,R7
    IR = IR_NOT;
    tick(); chk("not_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("not_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("not_u3", E_RZ, 4'd7, 5'b10010, 1'b1, 1'b0);
    tick(); chk("not_u4", E_WB, 4'd6, 5'd0, 1'b1, 1'b0);
    tick(); chk("not_next_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);

    // Undefined opcode behaves as nop
    IR = IR_UNDEF;
    tick(); chk("undef_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("undef_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("undef_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);

    // add with three wait cycles in T1
    IR = IR_ADD; mem_ready = 1'b0;
    tick(); chk("wait_t1_a", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_t1_b", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_t1_c", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_t1_d", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    mem_ready = 1'b1;
    tick(); chk("wait_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_r3", E_RY, 4'd2, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_r4", E_RZ, 4'd3, 5'b00011, 1'b1, 1'b0);
    tick(); chk("wait_r5", E_WB, 4'd1, 5'd0, 1'b1, 1'b0);
    tick(); chk("wait_next_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);

    // mul R4,R5
    IR = IR_MUL;
    tick(); chk("mul_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("mul_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("mul_m3", E_RY, 4'd4, 5'd0, 1'b1, 1'b0);
    tick(); chk("mul_m4", E_RZ, 4'd5, 5'b01111, 1'b1, 1'b0);
    tick(); chk("mul_m5", E_M5, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("mul_m6", E_M6, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("mul_next_t0", E_T0, 4'd0, 5'd0, 1'b1, 1'b0);

    // halt, then run_in/mem_ready pulses must not move it
    IR = IR_HALT;
    tick(); chk("halt_t1", E_T1, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("halt_t2", E_T2, 4'd0, 5'd0, 1'b1, 1'b0);
    tick(); chk("halted", E_NONE, 4'd0, 5'd0, 1'b0, 1'b1);
    run_in = 1'b0; mem_ready = 1'b0; IR = IR_ADD;
    tick(); run_in = 1'b1; mem_ready = 1'b1;
    tick(); chk("halted_pulse", E_NONE, 4'd0, 5'd0, 1'b0, 1'b1);
    run_in = 1'b0;
    tick(); chk("halted_stay", E_NONE, 4'd0, 5'd0, 1'b0, 1'b1);
    #2 clear = 1'b0;
    #1 chk("halt_clear", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);
    tick(); clear = 1'b1;
    tick(); chk("halt_idle", E_NONE, 4'd0, 5'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
